// File: rtl/ssd_scan_driver_if.sv
// rtl/ssd_scan_driver_if.sv - value/handshake and display lines of the seven-segment scan driver
interface ssd_scan_driver_if #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 13
);
    logic [VALUE_WIDTH-1:0] value;
    logic                   is_signed;
    logic                   load;
    logic                   busy;
    logic                   overflow;
    logic [NUM_DIGITS-1:0]  anode;
    logic [6:0]             segments;

    modport master (
        output value, is_signed, load,
        input  busy, overflow, anode, segments
    );

    modport slave (
        input  value, is_signed, load,
        output busy, overflow, anode, segments
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - binary-to-BCD seven-segment scan driver with sign, blanking and overflow
module ssd_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 13,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_BLANK    = 1
) (
    input  logic             clk,
    input  logic             rst,
    ssd_scan_driver_if.slave bus
);
    localparam int BCD_DIGITS = (VALUE_WIDTH * 30103 + 99999) / 100000 + 1;
    localparam int BW         = 4 * BCD_DIGITS;
    localparam int EXT_DIGITS = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;
    localparam int EW         = 4 * EXT_DIGITS;
    localparam int CW         = $clog2(VALUE_WIDTH + 1);
    localparam int RW         = $clog2(REFRESH_DIV);
    localparam int IW         = $clog2(NUM_DIGITS);
    localparam logic [3:0] SYM_DASH  = 4'd10;
    localparam logic [3:0] SYM_BLANK = 4'd11;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                 state, state_nxt;
    logic [VALUE_WIDTH-1:0] bin;
    logic [BW-1:0]          bcd, bcd_adj;
    logic [EW-1:0]          bcd_ext;
    logic [CW-1:0]          iter;
    logic                   neg;
    logic [3:0]             disp [NUM_DIGITS];
    logic [3:0]             disp_nxt [NUM_DIGITS];
    logic                   ovf, ovf_nxt, upper_nz;
    logic [IW-1:0]          msd;
    logic [RW-1:0]          rcnt;
    logic [IW-1:0]          idx;
    logic [NUM_DIGITS-1:0]  anode_q;
    logic [6:0]             seg_q;

    function automatic logic [6:0] seg_code(input logic [3:0] sym);
        logic [6:0] c;
        case (sym)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            4'd10:   c = 7'h3F;
            default: c = 7'h7F;
        endcase
        return (ACTIVE_LOW != 0) ? c : ~c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load) state_nxt = CONVERT;
            CONVERT: if (iter == CW'(VALUE_WIDTH - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Double-dabble: add 3 to every digit >= 5, then shift the next binary bit in.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < BCD_DIGITS; d++)
            if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            bcd  <= '0;
            iter <= '0;
            neg  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.load) begin
                    neg  <= bus.is_signed & bus.value[VALUE_WIDTH-1];
                    bin  <= (bus.is_signed & bus.value[VALUE_WIDTH-1]) ? -bus.value : bus.value;
                    bcd  <= '0;
                    iter <= '0;
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    iter       <= iter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bcd_ext = EW'(bcd);

    always_comb begin
        upper_nz = 1'b0;
        for (int d = NUM_DIGITS; d < EXT_DIGITS; d++)
            if (bcd_ext[4*d +: 4] != 4'd0) upper_nz = 1'b1;
        msd = '0;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (bcd_ext[4*d +: 4] != 4'd0) msd = IW'(d);
        // A negative value also needs the top display digit for its '-'.
        ovf_nxt = upper_nz | (neg & (msd == IW'(NUM_DIGITS - 1)));
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (ovf_nxt)
                disp_nxt[d] = SYM_DASH;
            else if (neg && ((LZ_BLANK != 0) ? (d == int'(msd) + 1) : (d == NUM_DIGITS - 1)))
                disp_nxt[d] = SYM_DASH;
            else if ((LZ_BLANK != 0) && (d > int'(msd)))
                disp_nxt[d] = SYM_BLANK;
            else
                disp_nxt[d] = bcd_ext[4*d +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) disp[d] <= SYM_BLANK;
        end else if (state == COMMIT) begin
            ovf <= ovf_nxt;
            for (int d = 0; d < NUM_DIGITS; d++) disp[d] <= disp_nxt[d];
        end
    end

    assign bus.overflow = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt    <= '0;
            idx     <= '0;
            anode_q <= (ACTIVE_LOW != 0) ? '1 : '0;
            seg_q   <= seg_code(SYM_BLANK);
        end else begin
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            anode_q <= (ACTIVE_LOW != 0) ? ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx)
                                         :  ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
            seg_q   <= seg_code(disp[idx]);
        end
    end

    assign bus.anode    = anode_q;
    assign bus.segments = seg_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed checks of ssd_scan_driver with leading-zero blanking on and off
module tb_ssd_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ssd_scan_driver_if #(.NUM_DIGITS(4), .VALUE_WIDTH(13)) bus ();
    ssd_scan_driver_if #(.NUM_DIGITS(4), .VALUE_WIDTH(13)) bus0 ();

    ssd_scan_driver #(
        .NUM_DIGITS(4), .VALUE_WIDTH(13), .REFRESH_DIV(4), .ACTIVE_LOW(1), .LZ_BLANK(1)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    ssd_scan_driver #(
        .NUM_DIGITS(4), .VALUE_WIDTH(13), .REFRESH_DIV(4), .ACTIVE_LOW(1), .LZ_BLANK(0)
    ) dut_lz0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic drive(input logic [12:0] v, input logic s, input logic l);
        bus.value = v;  bus.is_signed = s;  bus.load = l;
        bus0.value = v; bus0.is_signed = s; bus0.load = l;
    endtask

    // Returns at the falling edge just after the capturing edge k.
    task automatic load_value(input logic [12:0] v, input logic s);
        @(negedge clk);
        drive(v, s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(v, s, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic read_digits(output logic [27:0] s1, output logic [27:0] s0);
        s1 = 'x;
        s0 = 'x;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (bus.anode  == ~(4'b0001 << i)) s1[7*i +: 7] = bus.segments;
                if (bus0.anode == ~(4'b0001 << i)) s0[7*i +: 7] = bus0.segments;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] s1, s0;
        logic [3:0]  exp_an;

        drive(13'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_anode", {28'd0, bus.anode}, 32'hF);
        check("rst_segments", {25'd0, bus.segments}, 32'h7F);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);

        rst = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << (((n - 1) / 4) % 4));
            check("idle_anode", {28'd0, bus.anode}, {28'd0, exp_an});
            check("idle_segments", {25'd0, bus.segments}, 32'h7F);
        end

        load_value(13'd1234, 1'b0);
        check("u1234_busy_k", {31'd0, bus.busy}, 32'd1);
        repeat (13) @(negedge clk);
        check("u1234_busy_k13", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("u1234_busy_k14", {31'd0, bus.busy}, 32'd0);
        read_digits(s1, s0);
        check("u1234_digits", {4'd0, s1}, {4'd0, pack4(7'h79, 7'h24, 7'h30, 7'h19)});
        check("u1234_overflow", {31'd0, bus.overflow}, 32'd0);

        load_value(13'h1F85, 1'b1);
        wait_idle("neg123_done");
        read_digits(s1, s0);
        check("neg123_digits", {4'd0, s1}, {4'd0, pack4(7'h3F, 7'h79, 7'h24, 7'h30)});
        check("neg123_digits_lz0", {4'd0, s0}, {4'd0, pack4(7'h3F, 7'h79, 7'h24, 7'h30)});
        check("neg123_overflow", {31'd0, bus.overflow}, 32'd0);

        load_value(13'h1C18, 1'b1);
        wait_idle("neg1000_done");
        read_digits(s1, s0);
        check("neg1000_overflow", {31'd0, bus.overflow}, 32'd1);
        check("neg1000_digits", {4'd0, s1}, {4'd0, pack4(7'h3F, 7'h3F, 7'h3F, 7'h3F)});

        load_value(13'd7, 1'b0);
        wait_idle("u7_done");
        read_digits(s1, s0);
        check("u7_overflow", {31'd0, bus.overflow}, 32'd0);
        check("u7_digits", {4'd0, s1}, {4'd0, pack4(7'h7F, 7'h7F, 7'h7F, 7'h78)});
        check("u7_digits_lz0", {4'd0, s0}, {4'd0, pack4(7'h40, 7'h40, 7'h40, 7'h78)});

        load_value(13'd500, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(13'd999, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(13'd999, 1'b0, 1'b0);
        wait_idle("u500_done");
        @(negedge clk);
        check("u500_not_requeued", {31'd0, bus.busy}, 32'd0);
        read_digits(s1, s0);
        check("u500_digits", {4'd0, s1}, {4'd0, pack4(7'h7F, 7'h12, 7'h40, 7'h40)});

        load_value(13'd42, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_anode", {28'd0, bus.anode}, 32'hF);
        @(negedge clk);
        rst = 1'b0;
        read_digits(s1, s0);
        check("rst_mid_digits", {4'd0, s1}, {4'd0, pack4(7'h7F, 7'h7F, 7'h7F, 7'h7F)});
        check("rst_mid_idle", {31'd0, bus.busy}, 32'd0);

        load_value(13'd0, 1'b0);
        wait_idle("zero_done");
        read_digits(s1, s0);
        check("zero_digits", {4'd0, s1}, {4'd0, pack4(7'h7F, 7'h7F, 7'h7F, 7'h40)});
        check("zero_digits_lz0", {4'd0, s0}, {4'd0, pack4(7'h40, 7'h40, 7'h40, 7'h40)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
